// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one data-memory transaction per accepted request over req/gnt/rvalid.
// Optional bus-error timeout on REQ+WAIT enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] Store_Data,
  output logic        Dmem_Req,
  output logic        Dmem_We,
  output logic [31:0] Dmem_Addr,
  output logic [3:0]  Dmem_Be,
  output logic [31:0] Dmem_Wdata,
  input  logic        Dmem_Gnt,
  input  logic        Dmem_Rvalid,
  input  logic [31:0] Dmem_Rdata,
  output logic [31:0] Load_Data,
  output logic        Done,
  output logic        Misaligned,
  output logic        Illegal,
  output logic        Bus_Err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;
  logic        illegal_q, misaligned_q, bus_err_q;

  logic        accept, is_illegal, is_misaligned, capture, abort, timeout_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = Req_Valid && (state_q == StIdle);

  // Request decode and store lane steering, evaluated on the accept cycle.
  always_comb begin
    is_illegal = (Mem_Read == Mem_Write) ||
                 (Mem_Read && (Funct3 == 3'b011 || Funct3 == 3'b110 || Funct3 == 3'b111)) ||
                 (Mem_Write && (Funct3[2] || Funct3 == 3'b011));
    is_misaligned = (Funct3[1:0] == 2'b01 && Addr[0]) ||
                    (Funct3[1:0] == 2'b10 && Addr[1:0] != 2'b00);
    be_n    = 4'b1111;
    wdata_n = Store_Data;
    if (Mem_Write) begin
      case (Funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << Addr[1:0];
          wdata_n = {4{Store_Data[7:0]}};
        end
        2'b01: begin
          be_n    = Addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{Store_Data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte  = Dmem_Rdata[8*off_q +: 8];
    ld_half  = off_q[1] ? Dmem_Rdata[31:16] : Dmem_Rdata[15:0];
    load_ext = Dmem_Rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'h0, ld_half};
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] cnt_q;

  assign timeout_hit = (cnt_q == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt_q <= '0;
    end else if (state_q == StReq || state_q == StWait) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = (is_illegal || is_misaligned) ? StDone : StReq;
      end
      StReq: begin
        if (Dmem_Gnt) begin
          if (we_q) begin
            state_d = StDone;
          end else if (Dmem_Rvalid) begin
            capture = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        if (Dmem_Rvalid) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      off_q        <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_q       <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q        <= Addr[1:0];
        funct3_q     <= Funct3;
        we_q         <= Mem_Write;
        addr_q       <= {Addr[31:2], 2'b00};
        be_q         <= be_n;
        wdata_q      <= wdata_n;
        illegal_q    <= is_illegal;
        misaligned_q <= !is_illegal && is_misaligned;
        bus_err_q    <= 1'b0;
      end
      if (capture) load_q <= load_ext;
      if (abort) bus_err_q <= 1'b1;
    end
  end

  assign Req_Ready  = (state_q == StIdle);
  assign Dmem_Req   = (state_q == StReq);
  assign Dmem_We    = (state_q == StReq) && we_q;
  assign Dmem_Addr  = addr_q;
  assign Dmem_Be    = be_q;
  assign Dmem_Wdata = wdata_q;
  assign Load_Data  = load_q;
  assign Done       = (state_q == StDone);
  assign Illegal    = illegal_q;
  assign Misaligned = misaligned_q;
  assign Bus_Err    = bus_err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu; the bench acts as the data memory.
module tb_riscv_lsu;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        Req_Valid, Req_Ready, Mem_Read, Mem_Write;
  logic [2:0]  Funct3;
  logic [31:0] Addr, Store_Data;
  logic        Dmem_Req, Dmem_We, Dmem_Gnt, Dmem_Rvalid;
  logic [31:0] Dmem_Addr, Dmem_Wdata, Dmem_Rdata, Load_Data;
  logic [3:0]  Dmem_Be;
  logic        Done, Misaligned, Illegal, Bus_Err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_load = '0;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Funct3(Funct3), .Addr(Addr),
    .Store_Data(Store_Data), .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We),
    .Dmem_Addr(Dmem_Addr), .Dmem_Be(Dmem_Be), .Dmem_Wdata(Dmem_Wdata),
    .Dmem_Gnt(Dmem_Gnt), .Dmem_Rvalid(Dmem_Rvalid), .Dmem_Rdata(Dmem_Rdata),
    .Load_Data(Load_Data), .Done(Done), .Misaligned(Misaligned), .Illegal(Illegal),
    .Bus_Err(Bus_Err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // g: Gnt in the (g+1)th REQ cycle, g<0 never grants; r: Rvalid r cycles after Gnt.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input int g, input int r, input logic [31:0] rdata);
    logic ld, ill, mis, bus;
    logic [1:0] o;
    logic [3:0] ebe;
    logic [31:0] ewd, eld, b32;
    int lat, exp_req, k, req_n, gnt_k;
    bit done_seen;
    o   = addr[1:0];
    ld  = rd && !wr;
    ill = (rd == wr) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (!ld && f3 > 2);
    mis = !ill && ((f3[1:0] == 2'd1 && o[0]) || (f3[1:0] == 2'd2 && o != 2'd0));
    bus = !ill && !mis && g < 0;
    ebe = 4'hf;
    ewd = sdata;
    if (!ld && f3 == 0) begin
      ebe = 4'(1 << o);
      ewd = {24'h0, sdata[7:0]} * 32'h01010101;
    end else if (!ld && f3 == 1) begin
      ebe = 4'(3 << o);
      ewd = {16'h0, sdata[15:0]} * 32'h00010001;
    end
    eld = model_load;
    if (ld && !ill && !mis && !bus) begin
      b32 = rdata >> (8 * o);
      case (f3)
        3'd0: begin eld = b32 & 32'hFF;   if (eld[7])  eld = eld | 32'hFFFFFF00; end
        3'd4: eld = b32 & 32'hFF;
        3'd1: begin eld = b32 & 32'hFFFF; if (eld[15]) eld = eld | 32'hFFFF0000; end
        3'd5: eld = b32 & 32'hFFFF;
        default: eld = rdata;
      endcase
    end
    if (ill || mis)  begin lat = 1;          exp_req = 0;     end
    else if (bus)    begin lat = TO + 1;     exp_req = TO;    end
    else if (ld)     begin lat = 2 + g + r;  exp_req = g + 1; end
    else             begin lat = 2 + g;      exp_req = g + 1; end

    check_eq("ready_before", Req_Ready, 1);
    Req_Valid = 1'b1; Mem_Read = rd; Mem_Write = wr; Funct3 = f3; Addr = addr; Store_Data = sdata;
    next_cycle();
    Req_Valid = 1'b0;
    k = 1; req_n = 0; gnt_k = -1; done_seen = 0;
    while (k <= 60) begin
      if (Dmem_Req) begin
        req_n++;
        check_eq("dmem_addr", Dmem_Addr, {addr[31:2], 2'b00});
        check_eq("dmem_be", 32'(Dmem_Be), 32'(ebe));
        check_eq("dmem_we", 32'(Dmem_We), 32'(!ld));
        if (!ld) check_eq("dmem_wdata", Dmem_Wdata, ewd);
      end
      if (Done) begin
        done_seen = 1;
        break;
      end
      Dmem_Gnt = 1'b0; Dmem_Rvalid = 1'b0; Dmem_Rdata = $urandom;
      if (Dmem_Req && g >= 0 && req_n == g + 1) begin
        Dmem_Gnt = 1'b1;
        gnt_k = k;
      end
      if (ld && gnt_k >= 0 && k == gnt_k + r) begin
        Dmem_Rvalid = 1'b1;
        Dmem_Rdata  = rdata;
      end
      // Busy-time requests must be ignored.
      Req_Valid = 1'($urandom_range(0, 1));
      Mem_Read = 1'($urandom); Mem_Write = 1'($urandom); Funct3 = 3'($urandom);
      Addr = $urandom; Store_Data = $urandom;
      next_cycle();
      k++;
    end
    Req_Valid = 1'b0; Dmem_Gnt = 1'b0; Dmem_Rvalid = 1'b0;
    check_eq("done_seen", 32'(done_seen), 1);
    check_eq("latency", k, lat);
    check_eq("req_cycles", req_n, exp_req);
    check_eq("illegal", 32'(Illegal), 32'(ill));
    check_eq("misaligned", 32'(Misaligned), 32'(mis));
    check_eq("bus_err", 32'(Bus_Err), 32'(bus));
    check_eq("load_data", Load_Data, eld);
    model_load = eld;
    next_cycle();
    check_eq("done_pulse", 32'(Done), 0);
    check_eq("ready_after", 32'(Req_Ready), 1);
  endtask

  initial begin
    logic [2:0] sel;
    rst = 1'b1; Req_Valid = 1'b0; Mem_Read = 1'b0; Mem_Write = 1'b0; Funct3 = '0;
    Addr = '0; Store_Data = '0; Dmem_Gnt = 1'b0; Dmem_Rvalid = 1'b0; Dmem_Rdata = '0;
    repeat (2) next_cycle();
    check_eq("rst_ready", 32'(Req_Ready), 1);
    check_eq("rst_req", 32'(Dmem_Req), 0);
    check_eq("rst_done", 32'(Done), 0);
    check_eq("rst_flags", {29'h0, Illegal, Misaligned, Bus_Err}, 0);
    check_eq("rst_addr", Dmem_Addr, 0);
    check_eq("rst_be_we", {27'h0, Dmem_We, Dmem_Be}, 0);
    check_eq("rst_wdata", Dmem_Wdata, 0);
    check_eq("rst_load", Load_Data, 0);
    rst = 1'b0;
    next_cycle();

    run_access(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    run_access(0, 1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 0);
    run_access(0, 1, 3'd1, 32'h102, 32'h00001234, 0, 0, 0);
    run_access(1, 0, 3'd0, 32'h203, 0, 0, 1, 32'h80FF7F01);
    run_access(1, 0, 3'd4, 32'h203, 0, 0, 1, 32'h80FF7F01);
    run_access(1, 0, 3'd1, 32'h200, 0, 0, 1, 32'h80FF7F01);
    run_access(1, 0, 3'd1, 32'h202, 0, 0, 1, 32'h80FF7F01);
    run_access(1, 0, 3'd2, 32'h300, 0, 0, 0, 32'h13579BDF);
    run_access(1, 0, 3'd2, 32'h102, 0, 0, 0, 32'hFFFFFFFF);
    run_access(1, 0, 3'd3, 32'h100, 0, 0, 0, 32'hFFFFFFFF);
    run_access(1, 1, 3'd2, 32'h100, 0, 0, 0, 32'hFFFFFFFF);
    run_access(0, 1, 3'd1, 32'h444, 32'hCAFEF00D, 4, 0, 0);

    // Reset while waiting for read data, then a stray Rvalid in IDLE.
    Req_Valid = 1'b1; Mem_Read = 1'b1; Mem_Write = 1'b0; Funct3 = 3'd2; Addr = 32'h500;
    next_cycle();
    Req_Valid = 1'b0; Dmem_Gnt = 1'b1;
    next_cycle();
    Dmem_Gnt = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0; model_load = '0;
    check_eq("rstw_req", 32'(Dmem_Req), 0);
    check_eq("rstw_done", 32'(Done), 0);
    check_eq("rstw_ready", 32'(Req_Ready), 1);
    Dmem_Rvalid = 1'b1; Dmem_Rdata = 32'h55AA55AA;
    next_cycle();
    Dmem_Rvalid = 1'b0;
    check_eq("late_rvalid_done", 32'(Done), 0);
    check_eq("late_rvalid_load", Load_Data, model_load);
    next_cycle();

`ifdef LSU_TIMEOUT_EN
    run_access(1, 0, 3'd2, 32'h600, 0, 0, 0, 32'h0BADF00D);
    run_access(1, 0, 3'd2, 32'h700, 0, -1, 0, 32'h0);
    run_access(0, 1, 3'd2, 32'h700, 32'h1, -1, 0, 32'h0);
`endif

    for (int i = 0; i < 200; i++) begin
      sel = 3'($urandom);
      run_access(sel == 0 ? 1'($urandom) : sel[0], sel == 0 ? 1'($urandom) : !sel[0],
                 3'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit directly downstream of the RV32I ALU. It takes the ALU result as the effective address and Read_Data2 as store data, and runs one data-memory transaction over a req/gnt/rvalid handshake. It returns sign- or zero-extended load data to writeback and raises Done to the pipeline control. Misaligned and illegal accesses are flagged without touching memory.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before bus-error abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
Req_Valid  input  1  access request from execute stage
Req_Ready  output  1  high only in IDLE; request accepted when Req_Valid && Req_Ready
Mem_Read  input  1  load request
Mem_Write  input  1  store request
Funct3  input  3  RV32I width/sign field
Addr  input  32  effective address (ALU_Out)
Store_Data  input  32  rs2 value (Read_Data2)
Dmem_Req  output  1  memory request, held until Dmem_Gnt
Dmem_We  output  1  1 = write
Dmem_Addr  output  32  word-aligned address, {Addr[31:2],2'b00}
Dmem_Be  output  4  byte enables
Dmem_Wdata  output  32  lane-aligned write data
Dmem_Gnt  input  1  memory accepted request
Dmem_Rvalid  input  1  read data valid
Dmem_Rdata  input  32  read word
Load_Data  output  32  extended load result, held until next load completes
Done  output  1  one-cycle completion pulse
Misaligned  output  1  valid with Done
Illegal  output  1  valid with Done
Bus_Err  output  1  valid with Done (0 unless LSU_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; Dmem_Req, Dmem_We, Done, Misaligned, Illegal, Bus_Err = 0; Dmem_Addr, Dmem_Be, Dmem_Wdata, Load_Data = 0.
- States: IDLE, REQ, WAIT, DONE. Req_Ready = (state==IDLE). Requests arriving in any other state are ignored.
- IDLE, on accept: register Addr, Funct3, direction and Store_Data.
  - Illegal: Mem_Read==Mem_Write, load Funct3 in {011,110,111}, or store Funct3 in {011,1xx}. Go to DONE with Illegal=1.
  - Misaligned (checked after the illegal check): halfword with Addr[0]!=0, or word with Addr[1:0]!=0. Go to DONE with Misaligned=1.
  - Otherwise go to REQ.
  - Erroneous accesses never assert Dmem_Req.
- REQ: Dmem_Req=1, with address, We, Be and Wdata stable until the Gnt cycle.
  - On Gnt, a store goes to DONE.
  - On Gnt, a load goes to WAIT. If Dmem_Rvalid is also high in the same cycle, capture data and go straight to DONE.
- WAIT: Dmem_Req=0. On Dmem_Rvalid, capture and extend into Load_Data, then go to DONE.
- DONE: Done=1 for exactly one cycle, flags valid, then return to IDLE. The next request can be accepted the cycle after DONE.
- Store lanes, with o=Addr[1:0]:
  - SB: Be=4'b0001<<o, Wdata={4{byte}}.
  - SH: Be = 0011 when o[1]=0, else 1100; Wdata={2{half}}.
  - SW: Be=1111.
  - Loads: Be=1111.
- Load extension:
  - LB/LBU: pick byte o; sign- or zero-extend.
  - LH/LHU: pick half o[1]; sign- or zero-extend.
  - LW: pass the word through.
- Latency with zero-wait memory (Gnt in the first REQ cycle): Done 2 cycles after accept for a store or same-cycle-Rvalid load; 3 cycles for a load with Rvalid one cycle after Gnt.
- rst mid-transaction: back to IDLE on that edge, Dmem_Req low next cycle, no Done. A late Rvalid arriving in IDLE is ignored.
- Load_Data is updated only by successful loads.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT, go to DONE with Bus_Err=1, drop Dmem_Req, and leave Load_Data unchanged.
- Undefined: no counter, Bus_Err tied 0, the LSU waits indefinitely.

Test Plan:
1. SW Addr=0x100, Store_Data=0xDEADBEEF, Gnt immediate -> Dmem_Addr=0x100, Be=1111, Wdata=0xDEADBEEF; Done 2 cycles after accept; flags 0.
2. SB Addr=0x103, Store_Data=0x000000A5 -> Be=1000, Wdata=0xA5A5A5A5. SH Addr=0x102, data 0x1234 -> Be=1100, Wdata=0x12341234.
3. Rdata=0x80FF7F01, Rvalid one cycle after Gnt:
   - LB @0x203 -> 0xFFFFFF80
   - LBU @0x203 -> 0x00000080
   - LH @0x200 -> 0x00007F01
   - LH @0x202 -> 0xFFFF80FF
   - Done 3 cycles after accept
4. LW Addr=0x102 -> Misaligned=1 with Done, Dmem_Req never asserted. Load Funct3=011 -> Illegal=1. Mem_Read=Mem_Write=1 -> Illegal=1.
5. Gnt delayed 4 cycles -> Dmem_Req held with stable Addr/Be/Wdata. Req_Valid pulses while busy are ignored. rst asserted in WAIT -> IDLE next cycle, no Done, Req_Ready=1.
6. With LSU_TIMEOUT_EN and TIMEOUT=8, no Gnt -> Done with Bus_Err=1 after 8 cycles in REQ, Dmem_Req drops, Load_Data unchanged.
